reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 70 +++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-read / 2-write register file with a walking zero-fill after reset,
// optional hardwired-zero entry 0, write-to-read bypass and same-address write conflict flag.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A4,
    input  logic [DATA_W-1:0] WD4,
    input  logic              WE4,
    output logic              busy,
    output logic              wr_conflict
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr3_ok, wr4_ok;

    // Writes to entry 0 are dropped entirely when it is hardwired to zero.
    assign wr3_ok = WE3 && !(ZERO_REG != 0 && A3 == '0);
    assign wr4_ok = WE4 && !(ZERO_REG != 0 && A4 == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= CLEAR;
            clr_ptr     <= '0;
            busy        <= 1'b1;
            wr_conflict <= 1'b0;
            mem[0]      <= '0;
        end else if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
            clr_ptr      <= clr_ptr + 1'b1;
            wr_conflict  <= 1'b0;
            if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end else begin
            if (wr3_ok) mem[A3] <= WD3;
            if (wr4_ok) mem[A4] <= WD4;
            wr_conflict <= wr3_ok && wr4_ok && A3 == A4;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return (state == CLEAR)                ? '0  :
               (ZERO_REG != 0 && a == '0)      ? '0  :
               (BYPASS != 0 && WE4 && A4 == a) ? WD4 :
               (BYPASS != 0 && WE3 && A3 == a) ? WD3 : mem[a];
    endfunction

    always_comb begin
        RD1 = rd(A1);
        RD2 = rd(A2);
    end
endmodule
